// File: rtl/slc_config_loader.sv
// rtl/slc_config_loader.sv - byte-serial configuration loader with XOR-checked atomic commit
module slc_config_loader #(
    parameter int NUM_LC   = 8,
    parameter int LC_CFG_W = 24
) (
    input  logic                         QCK,
    input  logic                         QRT,
    input  logic [7:0]                   CFG_DI,
    input  logic                         CFG_VLD,
    output logic                         CFG_RDY,
    output logic [NUM_LC*LC_CFG_W-1:0]   LC_CFG,
    output logic [NUM_LC-1:0]            LC_CFG_WE,
    output logic                         CFG_BUSY,
    output logic                         CFG_DONE,
    output logic                         CFG_ERR
);

    localparam int         NBYTES = NUM_LC * 3;
    localparam logic [4:0] LAST   = 5'(NBYTES - 1);
    localparam logic [7:0] HDR    = 8'hA5;

    typedef enum logic [1:0] {IDLE, LOAD, CHECK, COMMIT} state_t;

    state_t                       state;
    state_t                       state_nxt;
    logic [4:0]                   cnt;
    logic [7:0]                   xor_acc;
    logic                         chk_ok;
    logic [7:0]                   shadow [NBYTES];
    logic [NUM_LC*LC_CFG_W-1:0]   shadow_flat;
    logic                         fire;

    assign CFG_RDY  = !QRT && (state != COMMIT);
    assign fire     = CFG_VLD && CFG_RDY;
    assign CFG_BUSY = (state != IDLE);

    always_ff @(posedge QCK) begin
        if (QRT) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (fire && CFG_DI == HDR) state_nxt = LOAD;
            LOAD:    if (fire && cnt == LAST)   state_nxt = CHECK;
            CHECK:   if (fire)                  state_nxt = COMMIT;
            COMMIT:                             state_nxt = IDLE;
            default:                            state_nxt = IDLE;
        endcase
    end

    // Shadow needs no reset: it is only ever published after a full frame has rewritten it.
    always_ff @(posedge QCK) begin
        if (!QRT && state == LOAD && fire) begin
            shadow[cnt] <= CFG_DI;
        end
    end

    always_comb begin
        shadow_flat = '0;
        for (int i = 0; i < NBYTES; i++) begin
            shadow_flat[i*8 +: 8] = shadow[i];
        end
    end

    always_ff @(posedge QCK) begin
        if (QRT) begin
            cnt       <= '0;
            xor_acc   <= '0;
            chk_ok    <= 1'b0;
            LC_CFG    <= '0;
            LC_CFG_WE <= '0;
            CFG_DONE  <= 1'b0;
            CFG_ERR   <= 1'b0;
        end else begin
            LC_CFG_WE <= '0;
            case (state)
                IDLE: begin
                    if (fire && CFG_DI == HDR) begin
                        CFG_DONE <= 1'b0;
                        CFG_ERR  <= 1'b0;
                        xor_acc  <= '0;
                        cnt      <= '0;
                    end
                end
                LOAD: begin
                    if (fire) begin
                        xor_acc <= xor_acc ^ CFG_DI;
                        if (cnt != LAST) cnt <= cnt + 5'd1;
                    end
                end
                CHECK: begin
                    if (fire) chk_ok <= (CFG_DI == xor_acc);
                end
                COMMIT: begin
                    if (chk_ok) begin
                        LC_CFG    <= shadow_flat;
                        LC_CFG_WE <= '1;
                        CFG_DONE  <= 1'b1;
                    end else begin
                        CFG_ERR   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_slc_config_loader.sv
// tb/tb_slc_config_loader.sv - randomized self-checking bench for slc_config_loader
module tb_slc_config_loader;

    localparam int N  = 8;
    localparam int W  = 24;
    localparam int NB = N * 3;

    logic             QCK = 1'b0;
    logic             QRT;
    logic [7:0]       CFG_DI;
    logic             CFG_VLD;
    logic             CFG_RDY;
    logic [N*W-1:0]   LC_CFG;
    logic [N-1:0]     LC_CFG_WE;
    logic             CFG_BUSY;
    logic             CFG_DONE;
    logic             CFG_ERR;

    slc_config_loader #(.NUM_LC(N), .LC_CFG_W(W)) dut (
        .QCK(QCK), .QRT(QRT), .CFG_DI(CFG_DI), .CFG_VLD(CFG_VLD), .CFG_RDY(CFG_RDY),
        .LC_CFG(LC_CFG), .LC_CFG_WE(LC_CFG_WE), .CFG_BUSY(CFG_BUSY),
        .CFG_DONE(CFG_DONE), .CFG_ERR(CFG_ERR)
    );

    always #5 QCK = ~QCK;

    int checks = 0;
    int passed = 0;
    int we_pulses = 0;
    int busy_cycles = 0;
    int rdy_low = 0;

    always @(negedge QCK) begin
        if (LC_CFG_WE != '0) we_pulses++;
        if (CFG_BUSY) busy_cycles++;
        if (!CFG_RDY) rdy_low++;
    end

    logic [7:0]     frm [$];
    logic [N*W-1:0] exp_cfg;
    logic [N*W-1:0] new_cfg;
    logic           exp_good;

    // Reference view of a frame: cell i is the little-endian concatenation of its three bytes.
    function automatic logic [N*W-1:0] cells_of();
        logic [N*W-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) r[i*W +: W] = {frm[3+3*i], frm[2+3*i], frm[1+3*i]};
        return r;
    endfunction

    function automatic logic frame_good();
        logic [7:0] x;
        x = 8'h00;
        for (int k = 1; k <= NB; k++) x = x ^ frm[k];
        return x == frm[NB+1];
    endfunction

    // kind 0: fixed pattern, 1: random, 2: random with header values as data
    task automatic build_frame(input int kind);
        logic [7:0] x;
        logic [7:0] b;
        frm = {};
        frm.push_back(8'hA5);
        x = 8'h00;
        for (int k = 0; k < NB; k++) begin
            if (kind == 0) b = (k % 3 == 0) ? 8'(k / 3) : (k % 3 == 1) ? 8'(8'h80 | (k / 3)) : 8'h1B;
            else if (kind == 2 && (k % 5 == 1)) b = 8'hA5;
            else b = 8'($urandom_range(0, 255));
            frm.push_back(b);
            x = x ^ b;
        end
        frm.push_back(x);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int guard;
        guard = 0;
        CFG_DI  = b;
        CFG_VLD = 1'b1;
        while (CFG_RDY !== 1'b1 && guard < 50) begin
            @(posedge QCK); #1;
            guard++;
        end
        if (guard >= 50) begin
            checks++;
            $display("FAIL rdy_timeout: CFG_RDY=%b required 1 within 50 cycles", CFG_RDY);
        end
        @(posedge QCK); #1;
        CFG_VLD = 1'b0;
    endtask

    task automatic send_frame(input int max_gap, input int first, input int last);
        for (int k = first; k <= last; k++) begin
            if (max_gap > 0) begin
                repeat ($urandom_range(0, max_gap)) begin
                    @(posedge QCK); #1;
                end
            end
            send_byte(frm[k]);
        end
    endtask

    task automatic test_reset();
        QRT = 1'b1; CFG_VLD = 1'b0; CFG_DI = 8'h00;
        @(negedge QCK);
        checks++; if (CFG_RDY !== 1'b0) $display("FAIL rdy_in_reset: got %b want 0", CFG_RDY); else passed++;
        @(posedge QCK); @(posedge QCK); #1;
        QRT = 1'b0;
        @(negedge QCK);
        checks++; if (LC_CFG !== '0) $display("FAIL reset_cfg: got %h want 0", LC_CFG); else passed++;
        checks++; if ({LC_CFG_WE, CFG_BUSY, CFG_DONE, CFG_ERR} !== '0)
            $display("FAIL reset_flags: got we=%h busy=%b done=%b err=%b want 0", LC_CFG_WE, CFG_BUSY, CFG_DONE, CFG_ERR);
        else passed++;
        checks++; if (CFG_RDY !== 1'b1) $display("FAIL reset_rdy: got %b want 1", CFG_RDY); else passed++;
        exp_cfg = '0;
        @(posedge QCK); #1;
    endtask

    task automatic test_good_frame();
        int b0, w0;
        build_frame(0);
        new_cfg = cells_of();
        b0 = busy_cycles; w0 = we_pulses;
        send_frame(0, 0, NB + 1);
        @(negedge QCK);
        checks++; if (CFG_RDY !== 1'b0 || LC_CFG_WE !== '0) $display("FAIL good_commit_cycle: rdy=%b we=%h want 0/00", CFG_RDY, LC_CFG_WE); else passed++;
        @(negedge QCK);
        exp_cfg = new_cfg;
        checks++; if (LC_CFG !== exp_cfg) $display("FAIL good_cfg: got %h want %h", LC_CFG, exp_cfg); else passed++;
        checks++; if (LC_CFG[3*W +: W] !== 24'h1B8303) $display("FAIL good_cell3: got %h want 1b8303", LC_CFG[3*W +: W]); else passed++;
        checks++; if (LC_CFG_WE !== 8'hFF || CFG_DONE !== 1'b1 || CFG_ERR !== 1'b0 || CFG_BUSY !== 1'b0)
            $display("FAIL good_flags: we=%h done=%b err=%b busy=%b want ff/1/0/0", LC_CFG_WE, CFG_DONE, CFG_ERR, CFG_BUSY);
        else passed++;
        checks++; if (busy_cycles - b0 != 26) $display("FAIL good_busy_len: got %0d want 26", busy_cycles - b0); else passed++;
        @(posedge QCK); #1;
        @(negedge QCK);
        checks++; if (we_pulses - w0 != 1) $display("FAIL good_we_count: got %0d want 1", we_pulses - w0); else passed++;
        @(posedge QCK); #1;
    endtask

    task automatic test_bad_checksum();
        int w0;
        build_frame(1);
        frm[NB+1] = frm[NB+1] ^ 8'h01;
        w0 = we_pulses;
        send_frame(0, 0, NB + 1);
        @(negedge QCK);
        @(negedge QCK);
        checks++; if (LC_CFG !== exp_cfg) $display("FAIL bad_cfg_kept: got %h want %h", LC_CFG, exp_cfg); else passed++;
        checks++; if (CFG_ERR !== 1'b1 || CFG_DONE !== 1'b0) $display("FAIL bad_flags: err=%b done=%b want 1/0", CFG_ERR, CFG_DONE); else passed++;
        checks++; if (we_pulses != w0) $display("FAIL bad_we: got %0d pulses want 0", we_pulses - w0); else passed++;
        @(posedge QCK); #1;
    endtask

    task automatic test_garbage_stall();
        int b0;
        b0 = busy_cycles;
        send_byte(8'h00);
        send_byte(8'h5A);
        @(negedge QCK);
        checks++; if (CFG_BUSY !== 1'b0 || busy_cycles != b0) $display("FAIL garbage_busy: busy=%b cycles=%0d want 0", CFG_BUSY, busy_cycles - b0); else passed++;
        checks++; if (CFG_ERR !== 1'b1) $display("FAIL garbage_err_sticky: got %b want 1", CFG_ERR); else passed++;
        @(posedge QCK); #1;
        build_frame(2);
        new_cfg = cells_of();
        send_frame(3, 0, NB + 1);
        @(negedge QCK);
        @(negedge QCK);
        exp_cfg = new_cfg;
        checks++; if (LC_CFG !== exp_cfg) $display("FAIL stall_cfg: got %h want %h", LC_CFG, exp_cfg); else passed++;
        checks++; if (CFG_DONE !== 1'b1 || CFG_ERR !== 1'b0 || LC_CFG_WE !== 8'hFF)
            $display("FAIL stall_flags: done=%b err=%b we=%h want 1/0/ff", CFG_DONE, CFG_ERR, LC_CFG_WE);
        else passed++;
        @(posedge QCK); #1;
    endtask

    task automatic test_reset_mid_frame();
        int w0;
        w0 = we_pulses;
        build_frame(1);
        send_frame(0, 0, 10);
        QRT = 1'b1;
        @(posedge QCK); #1;
        QRT = 1'b0;
        exp_cfg = '0;
        @(negedge QCK);
        checks++; if (LC_CFG !== '0 || CFG_BUSY !== 1'b0 || CFG_DONE !== 1'b0 || CFG_ERR !== 1'b0)
            $display("FAIL midreset_state: cfg=%h busy=%b done=%b err=%b want 0", LC_CFG, CFG_BUSY, CFG_DONE, CFG_ERR);
        else passed++;
        @(posedge QCK); #1;
        build_frame(1);
        new_cfg = cells_of();
        send_frame(0, 0, NB + 1);
        @(negedge QCK);
        @(negedge QCK);
        exp_cfg = new_cfg;
        checks++; if (LC_CFG !== exp_cfg) $display("FAIL midreset_cfg: got %h want %h", LC_CFG, exp_cfg); else passed++;
        @(posedge QCK); #1;
        checks++; if (we_pulses - w0 != 1) $display("FAIL midreset_we: got %0d pulses want 1", we_pulses - w0); else passed++;
    endtask

    task automatic test_back_to_back();
        int r0;
        build_frame(1);
        new_cfg = cells_of();
        r0 = rdy_low;
        send_frame(0, 0, NB + 1);
        CFG_DI = 8'hA5; CFG_VLD = 1'b1;
        @(negedge QCK);
        checks++; if (CFG_RDY !== 1'b0) $display("FAIL b2b_commit_rdy: got %b want 0", CFG_RDY); else passed++;
        @(negedge QCK);
        exp_cfg = new_cfg;
        checks++; if (CFG_DONE !== 1'b1 || LC_CFG !== exp_cfg || LC_CFG_WE !== 8'hFF)
            $display("FAIL b2b_first: done=%b we=%h cfg=%h want 1/ff/%h", CFG_DONE, LC_CFG_WE, LC_CFG, exp_cfg);
        else passed++;
        @(posedge QCK); #1;
        CFG_VLD = 1'b0;
        checks++; if (CFG_DONE !== 1'b0) $display("FAIL b2b_done_clear: got %b want 0", CFG_DONE); else passed++;
        checks++; if (rdy_low - r0 != 1) $display("FAIL b2b_rdy_gap: got %0d cycles want 1", rdy_low - r0); else passed++;
        build_frame(1);
        new_cfg = cells_of();
        send_frame(0, 1, NB + 1);
        @(negedge QCK);
        @(negedge QCK);
        exp_cfg = new_cfg;
        checks++; if (CFG_DONE !== 1'b1 || LC_CFG !== exp_cfg) $display("FAIL b2b_second: done=%b cfg=%h want 1/%h", CFG_DONE, LC_CFG, exp_cfg); else passed++;
        @(posedge QCK); #1;
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 6; f++) begin
            build_frame(1 + (f % 2));
            if ($urandom_range(0, 2) == 0) frm[NB+1] = frm[NB+1] ^ 8'(1 << $urandom_range(0, 7));
            exp_good = frame_good();
            new_cfg  = cells_of();
            send_frame(f % 3, 0, NB + 1);
            @(negedge QCK);
            @(negedge QCK);
            if (exp_good) exp_cfg = new_cfg;
            checks++; if (LC_CFG !== exp_cfg) $display("FAIL rand_cfg[%0d]: got %h want %h", f, LC_CFG, exp_cfg); else passed++;
            checks++; if (CFG_DONE !== exp_good || CFG_ERR !== !exp_good || LC_CFG_WE !== (exp_good ? 8'hFF : 8'h00))
                $display("FAIL rand_flags[%0d]: done=%b err=%b we=%h want good=%b", f, CFG_DONE, CFG_ERR, LC_CFG_WE, exp_good);
            else passed++;
            @(posedge QCK); #1;
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_garbage_stall();
        test_reset_mid_frame();
        test_back_to_back();
        test_random_frames();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
